icache_refill_ctrl: RTL

- Direct-mapped instruction cache controller between the fetch stage and the instruction memory's block read port.
- Serves word fetches from internal line storage on a hit.
- On a miss, drives the block-aligned address to instruction memory, waits a programmable latency, captures the whole BLOCK_SIZE-word block, installs it and returns the requested word.
- Provides flush, stall handshake and hit/miss performance counters.

---
 rtl/icache_refill_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped instruction cache with whole-block refill from a fixed-latency
// block read port, flush support and hit/miss performance counters.
module icache_refill_ctrl #(
  parameter int WORD_SIZE    = 32,
  parameter int BLOCK_SIZE   = 16,
  parameter int NUM_LINES    = 8,
  parameter int MISS_LATENCY = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fetch_req,
  input  logic [WORD_SIZE-1:0]             fetch_addr,
  output logic                             fetch_ready,
  output logic                             fetch_valid,
  output logic [WORD_SIZE-1:0]             fetch_inst,
  input  logic                             flush,
  output logic                             mem_req,
  output logic [WORD_SIZE-1:0]             mem_addr,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0]  mem_block,
  output logic [CNT_WIDTH-1:0]             hit_count,
  output logic [CNT_WIDTH-1:0]             miss_count
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = WORD_SIZE - 4 - IDX_BITS;
  localparam int LAT_BITS = $clog2(MISS_LATENCY + 1);
  localparam int BLK_BITS = WORD_SIZE * BLOCK_SIZE;

  typedef enum logic [1:0] {IDLE, TAG, REFILL} state_t;

  state_t                 state, state_next;
  logic [WORD_SIZE-1:0]   addr_q;
  logic [LAT_BITS-1:0]    cnt;
  logic [NUM_LINES-1:0]   valid;
  logic                   flush_pending;
  logic [TAG_BITS-1:0]    tag_mem  [NUM_LINES];
  logic [BLK_BITS-1:0]    data_mem [NUM_LINES];

  logic [3:0]             off;
  logic [IDX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]    tag;
  logic                   hit;
  logic                   fill_done;

  assign off       = addr_q[3:0];
  assign idx       = addr_q[4+IDX_BITS-1:4];
  assign tag       = addr_q[WORD_SIZE-1:4+IDX_BITS];
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign fill_done = (state == REFILL) && (cnt == '0);

  // Word 0 sits in the most significant slice of a block.
  function automatic logic [WORD_SIZE-1:0] word_sel(input logic [BLK_BITS-1:0] blk,
                                                    input logic [3:0] o);
    logic [WORD_SIZE-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
      if (o == k[3:0]) w = blk[(BLOCK_SIZE-1-k)*WORD_SIZE +: WORD_SIZE];
    end
    return w;
  endfunction

  always_comb begin
    state_next  = state;
    fetch_ready = 1'b0;
    mem_req     = 1'b0;
    case (state)
      IDLE: begin
        fetch_ready = ~flush & ~flush_pending;
        if (fetch_req && fetch_ready) state_next = TAG;
      end
      TAG:     state_next = hit ? IDLE : REFILL;
      REFILL: begin
        mem_req = 1'b1;
        if (cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid         <= '0;
      flush_pending <= 1'b0;
      addr_q        <= '0;
      cnt           <= '0;
      fetch_valid   <= 1'b0;
      fetch_inst    <= '0;
      mem_addr      <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pending) begin
            valid         <= '0;
            flush_pending <= 1'b0;
          end else if (fetch_req) begin
            addr_q <= fetch_addr;
          end
        end
        TAG: begin
          if (flush) flush_pending <= 1'b1;
          if (hit) begin
            fetch_inst  <= word_sel(data_mem[idx], off);
            fetch_valid <= 1'b1;
            hit_count   <= hit_count + 1'b1;
          end else begin
            mem_addr   <= {tag, idx, 4'b0000};
            cnt        <= LAT_BITS'(MISS_LATENCY - 1);
            miss_count <= miss_count + 1'b1;
          end
        end
        REFILL: begin
          if (flush) flush_pending <= 1'b1;
          if (cnt == '0) begin
            valid[idx]  <= 1'b1;
            fetch_inst  <= word_sel(mem_block, off);
            fetch_valid <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Arrays carry no reset; an aborted refill never writes since state resets to IDLE.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_mem[idx] <= mem_block;
      tag_mem[idx]  <= tag;
    end
  end

endmodule
